// File: rtl/ceespu_pkg.sv
// Shared encodings for the ceespu memory stage: writeback source, load size
// and extension select, and the memory-stage state type.
package ceespu_pkg;

    localparam logic [1:0] SELWB_ALU  = 2'd0;
    localparam logic [1:0] SELWB_LOAD = 2'd1;
    localparam logic [1:0] SELWB_LINK = 2'd2;
    localparam logic [1:0] SELWB_ZERO = 2'd3;

    localparam logic [1:0] SELMEM_WORD = 2'd0;
    localparam logic [1:0] SELMEM_HALF = 2'd1;
    localparam logic [1:0] SELMEM_BYTE = 2'd2;
    localparam int         SELMEM_ZEXT_BIT = 2;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } mem_state_e;

endpackage

// File: rtl/ceespu_load_align.sv
// Combinational load aligner: picks the addressed byte/half lane out of the
// bus read word and sign- or zero-extends it to 32 bits.
module ceespu_load_align
    import ceespu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [2:0]  sel_mem,
    output logic [31:0] result
);

    logic        zext;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        zext      = sel_mem[SELMEM_ZEXT_BIT];
        byte_lane = rdata[{addr, 3'b000} +: 8];
        // Half lane follows address bit 0 to match the execute-stage store strobes.
        half_lane = addr[0] ? rdata[31:16] : rdata[15:0];
        result    = rdata;
        case (sel_mem[1:0])
            SELMEM_BYTE: result = zext ? {24'b0, byte_lane} : {{24{byte_lane[7]}}, byte_lane};
            SELMEM_HALF: result = zext ? {16'b0, half_lane} : {{16{half_lane[15]}}, half_lane};
            default:     result = rdata;
        endcase
    end

endmodule

// File: rtl/ceespu_memory.sv
// ceespu memory stage: drives the data bus with a req/ack handshake, stalls
// upstream while an access is outstanding and produces the register writeback.
module ceespu_memory
    import ceespu_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        I_clk,
    input  logic        I_rst,
    input  logic        I_we,
    input  logic [4:0]  I_regD,
    input  logic [31:0] I_aluResult,
    input  logic [1:0]  I_selWb,
    input  logic [2:0]  I_selMem,
    input  logic        I_memE,
    input  logic [3:0]  I_memWe,
    input  logic [31:0] I_memAddress,
    input  logic [31:0] I_storeData,
    input  logic [13:0] I_PC,
    input  logic        I_busAck,
    input  logic [31:0] I_busRData,
    output logic        O_busReq,
    output logic [31:0] O_busAddr,
    output logic [31:0] O_busWData,
    output logic [3:0]  O_busWe,
    output logic        O_we,
    output logic [4:0]  O_regD,
    output logic [31:0] O_wbData,
    output logic        O_busErr,
    output logic        O_stall
);

    localparam logic [CNT_W-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

    mem_state_e  state_q, state_d;
    logic        bus_req_q, bus_req_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic [3:0]  bus_we_q, bus_we_d;
    logic        we_q, we_d;
    logic [4:0]  regd_q, regd_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic        bus_err_q, bus_err_d;
    logic        lat_we_q, lat_we_d;
    logic [4:0]  lat_regd_q, lat_regd_d;
    logic [1:0]  lat_selwb_q, lat_selwb_d;
    logic [2:0]  lat_selmem_q, lat_selmem_d;
    logic [31:0] lat_src_q, lat_src_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [31:0] src_mux;
    logic [31:0] load_data;
    logic        timeout_hit;
    logic        stall_c;

    ceespu_load_align u_align (
        .rdata   (I_busRData),
        .addr    (bus_addr_q[1:0]),
        .sel_mem (lat_selmem_q),
        .result  (load_data)
    );

    always_comb begin
        src_mux = 32'd0;
        case (I_selWb)
            SELWB_ALU:  src_mux = I_aluResult;
            SELWB_LINK: src_mux = {18'b0, I_PC} + 32'd1;
            default:    src_mux = 32'd0;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        bus_req_d    = bus_req_q;
        bus_addr_d   = bus_addr_q;
        bus_wdata_d  = bus_wdata_q;
        bus_we_d     = bus_we_q;
        we_d         = we_q;
        regd_d       = regd_q;
        wb_data_d    = wb_data_q;
        bus_err_d    = 1'b0;
        lat_we_d     = lat_we_q;
        lat_regd_d   = lat_regd_q;
        lat_selwb_d  = lat_selwb_q;
        lat_selmem_d = lat_selmem_q;
        lat_src_d    = lat_src_q;
        count_d      = count_q;
        stall_c      = 1'b0;
        timeout_hit  = (TIMEOUT != 0) && (state_q == ST_ACCESS) && !I_busAck &&
                       (count_q == TO_LAST);

        case (state_q)
            ST_IDLE: begin
                if (I_memE) begin
                    stall_c      = 1'b1;
                    bus_req_d    = 1'b1;
                    bus_addr_d   = I_memAddress;
                    bus_wdata_d  = I_storeData;
                    bus_we_d     = I_memWe;
                    lat_we_d     = I_we;
                    lat_regd_d   = I_regD;
                    lat_selwb_d  = I_selWb;
                    lat_selmem_d = I_selMem;
                    lat_src_d    = src_mux;
                    we_d         = 1'b0;
                    count_d      = '0;
                    state_d      = ST_ACCESS;
                end else begin
                    we_d      = I_we;
                    regd_d    = I_regD;
                    wb_data_d = src_mux;
                end
            end
            ST_ACCESS: begin
                stall_c = !I_busAck && !timeout_hit;
                if (I_busAck) begin
                    bus_req_d = 1'b0;
                    we_d      = lat_we_q;
                    regd_d    = lat_regd_q;
                    wb_data_d = (lat_selwb_q == SELWB_LOAD) ? load_data : lat_src_q;
                    state_d   = ST_IDLE;
                end else if (timeout_hit) begin
                    // Abandon the access so a dead slave cannot hang the core.
                    bus_req_d = 1'b0;
                    bus_err_d = 1'b1;
                    we_d      = 1'b0;
                    state_d   = ST_IDLE;
                end else begin
                    count_d = count_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge I_clk) begin
        if (!I_rst) begin
            state_q      <= ST_IDLE;
            bus_req_q    <= 1'b0;
            bus_addr_q   <= 32'd0;
            bus_wdata_q  <= 32'd0;
            bus_we_q     <= 4'd0;
            we_q         <= 1'b0;
            regd_q       <= 5'd0;
            wb_data_q    <= 32'd0;
            bus_err_q    <= 1'b0;
            lat_we_q     <= 1'b0;
            lat_regd_q   <= 5'd0;
            lat_selwb_q  <= 2'd0;
            lat_selmem_q <= 3'd0;
            lat_src_q    <= 32'd0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            bus_req_q    <= bus_req_d;
            bus_addr_q   <= bus_addr_d;
            bus_wdata_q  <= bus_wdata_d;
            bus_we_q     <= bus_we_d;
            we_q         <= we_d;
            regd_q       <= regd_d;
            wb_data_q    <= wb_data_d;
            bus_err_q    <= bus_err_d;
            lat_we_q     <= lat_we_d;
            lat_regd_q   <= lat_regd_d;
            lat_selwb_q  <= lat_selwb_d;
            lat_selmem_q <= lat_selmem_d;
            lat_src_q    <= lat_src_d;
            count_q      <= count_d;
        end
    end

    assign O_busReq   = bus_req_q;
    assign O_busAddr  = bus_addr_q;
    assign O_busWData = bus_wdata_q;
    assign O_busWe    = bus_we_q;
    assign O_we       = we_q;
    assign O_regD     = regd_q;
    assign O_wbData   = wb_data_q;
    assign O_busErr   = bus_err_q;
    assign O_stall    = stall_c & I_rst;

endmodule

// File: tb/tb_ceespu_memory.sv
// Self-checking bench for ceespu_memory: directed scenarios followed by random
// instructions checked against a transaction-level model of the stage.
module tb_ceespu_memory;

    localparam int TO = 4;

    logic        I_clk;
    logic        I_rst;
    logic        I_we;
    logic [4:0]  I_regD;
    logic [31:0] I_aluResult;
    logic [1:0]  I_selWb;
    logic [2:0]  I_selMem;
    logic        I_memE;
    logic [3:0]  I_memWe;
    logic [31:0] I_memAddress;
    logic [31:0] I_storeData;
    logic [13:0] I_PC;
    logic        I_busAck;
    logic [31:0] I_busRData;
    logic        O_busReq;
    logic [31:0] O_busAddr;
    logic [31:0] O_busWData;
    logic [3:0]  O_busWe;
    logic        O_we;
    logic [4:0]  O_regD;
    logic [31:0] O_wbData;
    logic        O_busErr;
    logic        O_stall;

    int checks = 0;
    int errors = 0;

    ceespu_memory #(.TIMEOUT(TO), .CNT_W(5)) dut (
        .I_clk        (I_clk),
        .I_rst        (I_rst),
        .I_we         (I_we),
        .I_regD       (I_regD),
        .I_aluResult  (I_aluResult),
        .I_selWb      (I_selWb),
        .I_selMem     (I_selMem),
        .I_memE       (I_memE),
        .I_memWe      (I_memWe),
        .I_memAddress (I_memAddress),
        .I_storeData  (I_storeData),
        .I_PC         (I_PC),
        .I_busAck     (I_busAck),
        .I_busRData   (I_busRData),
        .O_busReq     (O_busReq),
        .O_busAddr    (O_busAddr),
        .O_busWData   (O_busWData),
        .O_busWe      (O_busWe),
        .O_we         (O_we),
        .O_regD       (O_regD),
        .O_wbData     (O_wbData),
        .O_busErr     (O_busErr),
        .O_stall      (O_stall)
    );

    initial I_clk = 1'b0;
    always #5 I_clk = ~I_clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference load: shift the addressed lane down, mask to size, then extend.
    function automatic logic [31:0] modelLoad(input logic [31:0] rdata, input logic [31:0] addr,
                                              input logic [2:0] selMem);
        int          sh;
        logic [31:0] mask;
        logic [31:0] v;
        if (selMem[1:0] == 2'd2) begin
            sh   = int'(addr[1:0]) * 8;
            mask = 32'hFF;
        end else if (selMem[1:0] == 2'd1) begin
            sh   = addr[0] ? 16 : 0;
            mask = 32'hFFFF;
        end else begin
            return rdata;
        end
        v = (rdata >> sh) & mask;
        if (!selMem[2] && ((v & ((mask + 32'd1) >> 1)) != 32'd0)) v = v | ~mask;
        return v;
    endfunction

    function automatic logic [31:0] modelSrc(input logic [1:0] selWb, input logic [31:0] alu,
                                             input logic [13:0] pc);
        if (selWb == 2'd0) return alu;
        if (selWb == 2'd2) return 32'(pc) + 32'd1;
        return 32'd0;
    endfunction

    // One instruction from IDLE; ackDelay = number of wait cycles before ack
    // (ackDelay >= TO means the slave never answers and the access times out).
    task automatic applyStimulus(input logic we, input logic [4:0] regD, input logic [31:0] alu,
                                 input logic [1:0] selWb, input logic [2:0] selMem,
                                 input logic memE, input logic [3:0] memWe,
                                 input logic [31:0] addr, input logic [31:0] sdata,
                                 input logic [13:0] pc, input logic [31:0] rdata,
                                 input int ackDelay);
        logic [31:0] expWb;
        logic        ack;
        I_we = we; I_regD = regD; I_aluResult = alu; I_selWb = selWb; I_selMem = selMem;
        I_memE = memE; I_memWe = memWe; I_memAddress = addr; I_storeData = sdata; I_PC = pc;
        I_busAck = 1'($urandom_range(0, 1));
        I_busRData = $urandom;
        @(negedge I_clk);
        checkOutput("idle_stall", 32'(O_stall), 32'(memE));
        @(posedge I_clk); #1;
        I_busAck = 1'b0;
        checkOutput("busErr_clear", 32'(O_busErr), 32'd0);
        if (!memE) begin
            checkOutput("alu_we", 32'(O_we), 32'(we));
            checkOutput("alu_regD", 32'(O_regD), 32'(regD));
            checkOutput("alu_wb", O_wbData, modelSrc(selWb, alu, pc));
            return;
        end
        checkOutput("req_set", 32'(O_busReq), 32'd1);
        checkOutput("bus_addr", O_busAddr, addr);
        checkOutput("bus_wdata", O_busWData, sdata);
        checkOutput("bus_we", 32'(O_busWe), 32'(memWe));
        checkOutput("we_pending", 32'(O_we), 32'd0);
        expWb = (selWb == 2'd1) ? modelLoad(rdata, addr, selMem) : modelSrc(selWb, alu, pc);
        for (int c = 0; c < TO; c++) begin
            ack = (c == ackDelay);
            I_busAck = ack;
            I_busRData = ack ? rdata : $urandom;
            @(negedge I_clk);
            checkOutput("access_stall", 32'(O_stall), 32'(!ack && (c != TO - 1)));
            @(posedge I_clk); #1;
            I_busAck = 1'b0;
            if (ack) begin
                checkOutput("ack_req", 32'(O_busReq), 32'd0);
                checkOutput("ack_err", 32'(O_busErr), 32'd0);
                checkOutput("ack_we", 32'(O_we), 32'(we));
                checkOutput("ack_regD", 32'(O_regD), 32'(regD));
                checkOutput("ack_wb", O_wbData, expWb);
                return;
            end else if (c == TO - 1) begin
                checkOutput("to_req", 32'(O_busReq), 32'd0);
                checkOutput("to_err", 32'(O_busErr), 32'd1);
                checkOutput("to_we", 32'(O_we), 32'd0);
            end else begin
                checkOutput("wait_req", 32'(O_busReq), 32'd1);
                checkOutput("wait_err", 32'(O_busErr), 32'd0);
            end
        end
    endtask

    initial begin
        I_rst = 1'b0; I_we = 1'b1; I_regD = 5'd7; I_aluResult = 32'h55; I_selWb = 2'd0;
        I_selMem = 3'd0; I_memE = 1'b1; I_memWe = 4'hF; I_memAddress = 32'h10;
        I_storeData = 32'h1; I_PC = 14'd3; I_busAck = 1'b1; I_busRData = 32'hFFFF_FFFF;

        repeat (2) @(posedge I_clk);
        #1;
        checkOutput("rst_stall", 32'(O_stall), 32'd0);
        checkOutput("rst_req", 32'(O_busReq), 32'd0);
        checkOutput("rst_we", 32'(O_we), 32'd0);
        checkOutput("rst_wb", O_wbData, 32'd0);
        checkOutput("rst_addr", O_busAddr, 32'd0);
        checkOutput("rst_err", 32'(O_busErr), 32'd0);
        I_rst = 1'b1; I_busAck = 1'b0;

        $display("[TB] directed scenarios");
        applyStimulus(1'b1, 5'd1, 32'h1234, 2'd0, 3'd0, 1'b0, 4'h0, 32'h0, 32'h0, 14'd0, 32'h0, 0);
        applyStimulus(1'b1, 5'd2, 32'h0, 2'd1, 3'b010, 1'b1, 4'h0, 32'h103, 32'h0, 14'd4,
                      32'h80FF_0000, 0);
        applyStimulus(1'b1, 5'd3, 32'h0, 2'd1, 3'b101, 1'b1, 4'h0, 32'h201, 32'h0, 14'd5,
                      32'hBEEF_1234, 3);
        applyStimulus(1'b0, 5'd0, 32'h0, 2'd0, 3'd0, 1'b1, 4'hF, 32'h40, 32'hDEADBEEF, 14'd6,
                      32'h0, 1);
        applyStimulus(1'b1, 5'd4, 32'h0, 2'd1, 3'd0, 1'b1, 4'h0, 32'h80, 32'h0, 14'd7,
                      32'h0, TO);
        applyStimulus(1'b1, 5'd5, 32'h0, 2'd1, 3'd0, 1'b1, 4'h0, 32'h84, 32'h0, 14'd8,
                      32'hCAFE_F00D, TO - 1);
        applyStimulus(1'b1, 5'd6, 32'h0, 2'd2, 3'd0, 1'b0, 4'h0, 32'h0, 32'h0, 14'h3FFF, 32'h0, 0);
        applyStimulus(1'b1, 5'd8, 32'h99, 2'd1, 3'd0, 1'b0, 4'h0, 32'h0, 32'h0, 14'd9, 32'h0, 0);

        // Reset in the second ACCESS cycle abandons the access.
        I_we = 1'b1; I_regD = 5'd9; I_selWb = 2'd1; I_selMem = 3'd0; I_memE = 1'b1;
        I_memWe = 4'h0; I_memAddress = 32'h300; I_busAck = 1'b0;
        @(posedge I_clk); #1;
        checkOutput("r6_req", 32'(O_busReq), 32'd1);
        @(posedge I_clk); #1;
        I_rst = 1'b0;
        @(negedge I_clk);
        checkOutput("r6_stall", 32'(O_stall), 32'd0);
        @(posedge I_clk); #1;
        checkOutput("r6_req_drop", 32'(O_busReq), 32'd0);
        checkOutput("r6_addr", O_busAddr, 32'd0);
        checkOutput("r6_regD", 32'(O_regD), 32'd0);
        I_rst = 1'b1; I_memE = 1'b0; I_we = 1'b0; I_selWb = 2'd0; I_aluResult = 32'd0;
        I_busAck = 1'b1; I_busRData = 32'h1234_5678;
        @(posedge I_clk); #1;
        I_busAck = 1'b0;
        checkOutput("r6_late_we", 32'(O_we), 32'd0);
        checkOutput("r6_late_req", 32'(O_busReq), 32'd0);
        checkOutput("r6_late_wb", O_wbData, 32'd0);

        $display("[TB] random instructions");
        for (int n = 0; n < 300; n++) begin
            logic        memE;
            logic [3:0]  memWe;
            logic [2:0]  selMem;
            memE   = 1'($urandom_range(0, 1));
            memWe  = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
            selMem = {1'($urandom), 2'($urandom_range(0, 2))};
            applyStimulus(1'($urandom), 5'($urandom), $urandom, 2'($urandom), selMem, memE, memWe,
                          $urandom, $urandom, 14'($urandom), $urandom,
                          int'($urandom_range(0, TO + 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
